// File: rtl/axi2ram_burst.sv
// rtl/axi2ram_burst.sv - AXI4 burst slave bridging to a 1R/1W synchronous RAM
// Independent write and read FSMs; reads stream through a 2-entry skid FIFO.
module axi2ram_burst #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_WORDS  = 1024,
  localparam int STRB_W    = DATA_WIDTH / 8,
  localparam int OFS       = $clog2(STRB_W),
  localparam int WAW       = $clog2(MEM_WORDS)
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [ID_WIDTH-1:0]   awid_i,
  input  logic [ADDR_WIDTH-1:0] awaddr_i,
  input  logic [7:0]            awlen_i,
  input  logic [2:0]            awsize_i,
  input  logic [1:0]            awburst_i,
  input  logic                  awvalid_i,
  output logic                  awready_o,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [STRB_W-1:0]     wstrb_i,
  input  logic                  wlast_i,
  input  logic                  wvalid_i,
  output logic                  wready_o,
  output logic [ID_WIDTH-1:0]   bid_o,
  output logic [1:0]            bresp_o,
  output logic                  bvalid_o,
  input  logic                  bready_i,
  input  logic [ID_WIDTH-1:0]   arid_i,
  input  logic [ADDR_WIDTH-1:0] araddr_i,
  input  logic [7:0]            arlen_i,
  input  logic [2:0]            arsize_i,
  input  logic [1:0]            arburst_i,
  input  logic                  arvalid_i,
  output logic                  arready_o,
  output logic [ID_WIDTH-1:0]   rid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic [1:0]            rresp_o,
  output logic                  rlast_o,
  output logic                  rvalid_o,
  input  logic                  rready_i,
  output logic                  mem_we_o,
  output logic [WAW-1:0]        mem_waddr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic [STRB_W-1:0]     mem_be_o,
  output logic                  mem_re_o,
  output logic [WAW-1:0]        mem_raddr_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_BURST} r_state_e;

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
      input logic [2:0] sz, input logic [7:0] len, input logic [1:0] bt);
    logic [ADDR_WIDTH-1:0] size_b, wrap_b, nxt, low, res;
    size_b = ADDR_WIDTH'(1) << sz;
    wrap_b = size_b * (ADDR_WIDTH'(len) + ADDR_WIDTH'(1));
    nxt    = (a & ~(size_b - ADDR_WIDTH'(1))) + size_b;
    low    = a & ~(wrap_b - ADDR_WIDTH'(1));
    case (bt)
      2'b00:   res = a;
      2'b10:   res = (nxt == low + wrap_b) ? low : nxt;
      default: res = nxt;
    endcase
    return res;
  endfunction

  // Narrow and unaligned beats only touch the lanes the address actually covers.
  function automatic logic [STRB_W-1:0] lane_mask(input logic [ADDR_WIDTH-1:0] a,
      input logic [2:0] sz);
    logic [ADDR_WIDTH-1:0] size_b;
    logic [STRB_W-1:0]     m;
    int lo, hi;
    size_b = ADDR_WIDTH'(1) << sz;
    lo = int'(a) % STRB_W;
    hi = int'(a & ~(size_b - ADDR_WIDTH'(1))) % STRB_W + int'(size_b) - 1;
    m  = '0;
    for (int i = 0; i < STRB_W; i++) m[i] = (i >= lo) && (i <= hi);
    return m;
  endfunction

  function automatic logic burst_err(input logic [2:0] sz, input logic [7:0] len,
      input logic [1:0] bt);
    logic wrap_bad;
    wrap_bad = (bt == 2'b10) &&
               !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
    return (32'(sz) > OFS) || (bt == 2'b11) || wrap_bad;
  endfunction

  function automatic logic addr_decerr(input logic [ADDR_WIDTH-1:0] a);
    return 32'(a[ADDR_WIDTH-1:OFS]) >= 32'(MEM_WORDS);
  endfunction

  // ---------------- write path ----------------
  w_state_e              w_state_q, w_state_d;
  logic                  awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [ID_WIDTH-1:0]   awid_q, awid_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [7:0]            awlen_q, awlen_d;
  logic [2:0]            awsize_q, awsize_d;
  logic [1:0]            awburst_q, awburst_d, bresp_q, bresp_d, w_beat_resp;
  logic [8:0]            wcnt_q, wcnt_d;
  logic                  w_hs, w_last, w_berr, w_decerr, w_write_ok;

  assign w_hs        = wready_q && wvalid_i;
  assign w_last      = (wcnt_q == {1'b0, awlen_q});
  assign w_berr      = burst_err(awsize_q, awlen_q, awburst_q);
  assign w_decerr    = addr_decerr(waddr_q);
  assign w_write_ok  = !w_berr && !w_decerr;
  assign w_beat_resp = w_decerr ? 2'b11 : ((w_berr || (wlast_i != w_last)) ? 2'b10 : 2'b00);

  always_comb begin
    w_state_d = w_state_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    awid_d    = awid_q;
    waddr_d   = waddr_q;
    awlen_d   = awlen_q;
    awsize_d  = awsize_q;
    awburst_d = awburst_q;
    wcnt_d    = wcnt_q;
    bresp_d   = bresp_q;
    case (w_state_q)
      W_IDLE: begin
        awready_d = 1'b1;
        if (awvalid_i && awready_q) begin
          awid_d    = awid_i;
          waddr_d   = awaddr_i;
          awlen_d   = awlen_i;
          awsize_d  = awsize_i;
          awburst_d = awburst_i;
          wcnt_d    = '0;
          bresp_d   = 2'b00;
          awready_d = 1'b0;
          wready_d  = 1'b1;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (w_hs) begin
          waddr_d = next_addr(waddr_q, awsize_q, awlen_q, awburst_q);
          wcnt_d  = wcnt_q + 9'd1;
          // Response encodings order by severity, so the worst beat is the largest.
          if (w_beat_resp > bresp_q) bresp_d = w_beat_resp;
          if (w_last) begin
            wready_d  = 1'b0;
            bvalid_d  = 1'b1;
            w_state_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        if (bready_i) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  assign awready_o   = awready_q;
  assign wready_o    = wready_q;
  assign bvalid_o    = bvalid_q;
  assign bid_o       = bvalid_q ? awid_q : '0;
  assign bresp_o     = bvalid_q ? bresp_q : 2'b00;
  assign mem_we_o    = w_hs && w_write_ok;
  assign mem_waddr_o = mem_we_o ? waddr_q[OFS+WAW-1:OFS] : '0;
  assign mem_wdata_o = mem_we_o ? wdata_i : '0;
  assign mem_be_o    = mem_we_o ? (wstrb_i & lane_mask(waddr_q, awsize_q)) : '0;

  // ---------------- read path ----------------
  r_state_e              r_state_q, r_state_d;
  logic                  arready_q, arready_d;
  logic [ID_WIDTH-1:0]   arid_q, arid_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic [7:0]            arlen_q, arlen_d;
  logic [2:0]            arsize_q, arsize_d;
  logic [1:0]            arburst_q, arburst_d;
  logic [8:0]            icnt_q, icnt_d;
  logic                  ret_q, ret_d, ret_last_q, ret_last_d;
  logic [1:0]            ret_resp_q, ret_resp_d;
  logic [DATA_WIDTH-1:0] fifo_data_q [2], fifo_data_d [2];
  logic [1:0]            fifo_resp_q [2], fifo_resp_d [2];
  logic                  fifo_last_q [2], fifo_last_d [2];
  logic                  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  r_berr, r_decerr, r_more, r_issue, r_valid, r_pop, bypass, push, fifo_pop;
  logic [DATA_WIDTH-1:0] ret_data, head_data;
  logic [1:0]            head_resp;
  logic                  head_last;

  assign r_berr   = burst_err(arsize_q, arlen_q, arburst_q);
  assign r_decerr = addr_decerr(raddr_q);
  assign r_more   = (icnt_q <= {1'b0, arlen_q});
  // Credit: beat in RAM flight plus buffered beats may never exceed the FIFO depth.
  assign r_issue  = (r_state_q == R_BURST) && r_more && ((cnt_q + {1'b0, ret_q}) < 2'd2);
  assign ret_data = (ret_resp_q == 2'b00) ? mem_rdata_i : '0;

  // The returning beat bypasses the FIFO when it is empty, keeping first data at T+2.
  assign head_data = (cnt_q != 2'd0) ? fifo_data_q[rd_ptr_q] : ret_data;
  assign head_resp = (cnt_q != 2'd0) ? fifo_resp_q[rd_ptr_q] : ret_resp_q;
  assign head_last = (cnt_q != 2'd0) ? fifo_last_q[rd_ptr_q] : ret_last_q;
  assign r_valid   = (cnt_q != 2'd0) || ret_q;
  assign r_pop     = r_valid && rready_i;
  assign fifo_pop  = r_pop && (cnt_q != 2'd0);
  assign bypass    = ret_q && (cnt_q == 2'd0) && rready_i;
  assign push      = ret_q && !bypass;

  always_comb begin
    r_state_d   = r_state_q;
    arready_d   = arready_q;
    arid_d      = arid_q;
    raddr_d     = raddr_q;
    arlen_d     = arlen_q;
    arsize_d    = arsize_q;
    arburst_d   = arburst_q;
    icnt_d      = icnt_q;
    ret_d       = r_issue;
    ret_resp_d  = r_decerr ? 2'b11 : (r_berr ? 2'b10 : 2'b00);
    ret_last_d  = (icnt_q == {1'b0, arlen_q});
    fifo_data_d = fifo_data_q;
    fifo_resp_d = fifo_resp_q;
    fifo_last_d = fifo_last_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q + {1'b0, push} - {1'b0, fifo_pop};
    if (push) begin
      fifo_data_d[wr_ptr_q] = ret_data;
      fifo_resp_d[wr_ptr_q] = ret_resp_q;
      fifo_last_d[wr_ptr_q] = ret_last_q;
      wr_ptr_d              = !wr_ptr_q;
    end
    if (fifo_pop) rd_ptr_d = !rd_ptr_q;
    case (r_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (arvalid_i && arready_q) begin
          arid_d    = arid_i;
          raddr_d   = araddr_i;
          arlen_d   = arlen_i;
          arsize_d  = arsize_i;
          arburst_d = arburst_i;
          icnt_d    = '0;
          arready_d = 1'b0;
          r_state_d = R_BURST;
        end
      end
      R_BURST: begin
        if (r_issue) begin
          raddr_d = next_addr(raddr_q, arsize_q, arlen_q, arburst_q);
          icnt_d  = icnt_q + 9'd1;
        end
        if (r_pop && head_last) begin
          arready_d = 1'b1;
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  assign arready_o   = arready_q;
  assign rvalid_o    = r_valid;
  assign rid_o       = r_valid ? arid_q : '0;
  assign rdata_o     = r_valid ? head_data : '0;
  assign rresp_o     = r_valid ? head_resp : 2'b00;
  assign rlast_o     = r_valid && head_last;
  assign mem_re_o    = r_issue && !r_berr && !r_decerr;
  assign mem_raddr_o = mem_re_o ? raddr_q[OFS+WAW-1:OFS] : '0;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      w_state_q  <= W_IDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      awid_q     <= '0;
      waddr_q    <= '0;
      awlen_q    <= '0;
      awsize_q   <= '0;
      awburst_q  <= '0;
      wcnt_q     <= '0;
      bresp_q    <= '0;
      r_state_q  <= R_IDLE;
      arready_q  <= 1'b0;
      arid_q     <= '0;
      raddr_q    <= '0;
      arlen_q    <= '0;
      arsize_q   <= '0;
      arburst_q  <= '0;
      icnt_q     <= '0;
      ret_q      <= 1'b0;
      ret_resp_q <= '0;
      ret_last_q <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        fifo_data_q[i] <= '0;
        fifo_resp_q[i] <= '0;
        fifo_last_q[i] <= 1'b0;
      end
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      w_state_q   <= w_state_d;
      awready_q   <= awready_d;
      wready_q    <= wready_d;
      bvalid_q    <= bvalid_d;
      awid_q      <= awid_d;
      waddr_q     <= waddr_d;
      awlen_q     <= awlen_d;
      awsize_q    <= awsize_d;
      awburst_q   <= awburst_d;
      wcnt_q      <= wcnt_d;
      bresp_q     <= bresp_d;
      r_state_q   <= r_state_d;
      arready_q   <= arready_d;
      arid_q      <= arid_d;
      raddr_q     <= raddr_d;
      arlen_q     <= arlen_d;
      arsize_q    <= arsize_d;
      arburst_q   <= arburst_d;
      icnt_q      <= icnt_d;
      ret_q       <= ret_d;
      ret_resp_q  <= ret_resp_d;
      ret_last_q  <= ret_last_d;
      fifo_data_q <= fifo_data_d;
      fifo_resp_q <= fifo_resp_d;
      fifo_last_q <= fifo_last_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_axi2ram_burst.sv
// tb/tb_axi2ram_burst.sv - directed bench for axi2ram_burst with a behavioural RAM
module tb_axi2ram_burst;
  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic [3:0]  awid_i, arid_i, bid_o, rid_o;
  logic [15:0] awaddr_i, araddr_i;
  logic [7:0]  awlen_i, arlen_i;
  logic [2:0]  awsize_i, arsize_i;
  logic [1:0]  awburst_i, arburst_i, bresp_o, rresp_o;
  logic        awvalid_i, awready_o, wlast_i, wvalid_i, wready_o, bvalid_o, bready_i;
  logic        arvalid_i, arready_o, rlast_o, rvalid_o, rready_i;
  logic [31:0] wdata_i, rdata_o, mem_wdata_o, mem_rdata_i;
  logic [3:0]  wstrb_i, mem_be_o;
  logic        mem_we_o, mem_re_o;
  logic [9:0]  mem_waddr_o, mem_raddr_o;

  logic [31:0] ram [1024];
  int n_checks = 0;
  int n_fails  = 0;

  logic [31:0] rd_data [16];
  logic [1:0]  rd_resp [16];
  logic        rd_last [16];
  logic [3:0]  rd_id   [16];
  logic [9:0]  re_addr [16];
  int          n_beats, n_re, max_out, first_rv, first_re, last_cyc;
  logic        we_log [16];
  logic [9:0]  wa_log [16];
  logic [3:0]  be_log [16];
  logic [31:0] wd_log [16];
  logic [3:0]  b_id;
  logic [1:0]  b_resp;
  logic        b_seen;

  always #5 clk_i = ~clk_i;

  axi2ram_burst dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .awid_i(awid_i), .awaddr_i(awaddr_i), .awlen_i(awlen_i), .awsize_i(awsize_i),
    .awburst_i(awburst_i), .awvalid_i(awvalid_i), .awready_o(awready_o),
    .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wlast_i(wlast_i), .wvalid_i(wvalid_i),
    .wready_o(wready_o), .bid_o(bid_o), .bresp_o(bresp_o), .bvalid_o(bvalid_o),
    .bready_i(bready_i), .arid_i(arid_i), .araddr_i(araddr_i), .arlen_i(arlen_i),
    .arsize_i(arsize_i), .arburst_i(arburst_i), .arvalid_i(arvalid_i),
    .arready_o(arready_o), .rid_o(rid_o), .rdata_o(rdata_o), .rresp_o(rresp_o),
    .rlast_o(rlast_o), .rvalid_o(rvalid_o), .rready_i(rready_i),
    .mem_we_o(mem_we_o), .mem_waddr_o(mem_waddr_o), .mem_wdata_o(mem_wdata_o),
    .mem_be_o(mem_be_o), .mem_re_o(mem_re_o), .mem_raddr_o(mem_raddr_o),
    .mem_rdata_i(mem_rdata_i)
  );

  always @(posedge clk_i) begin
    if (mem_re_o) mem_rdata_i <= ram[mem_raddr_o];
    if (mem_we_o)
      for (int b = 0; b < 4; b++)
        if (mem_be_o[b]) ram[mem_waddr_o][b*8 +: 8] <= mem_wdata_o[b*8 +: 8];
  end

  task automatic run_write(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len,
      input logic [2:0] size, input logic [1:0] burst, input logic [31:0] base,
      input logic [3:0] strb, input int last_pos);
    int k;
    b_id = '0; b_resp = '0; b_seen = 1'b0; k = 0;
    @(negedge clk_i);
    awid_i = id; awaddr_i = addr; awlen_i = len; awsize_i = size; awburst_i = burst;
    awvalid_i = 1'b1;
    #1;
    while (!awready_o && k < 20) begin @(negedge clk_i); #1; k++; end
    @(negedge clk_i);
    awvalid_i = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wdata_i = base + 32'(i); wstrb_i = strb; wlast_i = (i == last_pos); wvalid_i = 1'b1;
      #1;
      k = 0;
      while (!wready_o && k < 20) begin @(negedge clk_i); #1; k++; end
      if (i < 16) begin
        we_log[i] = mem_we_o; wa_log[i] = mem_waddr_o; be_log[i] = mem_be_o; wd_log[i] = mem_wdata_o;
      end
      @(negedge clk_i);
    end
    wvalid_i = 1'b0; wlast_i = 1'b0;
    #1;
    k = 0;
    while (!bvalid_o && k < 20) begin @(negedge clk_i); #1; k++; end
    b_seen = bvalid_o; b_id = bid_o; b_resp = bresp_o;
    bready_i = 1'b1;
    @(negedge clk_i);
    bready_i = 1'b0;
  endtask

  task automatic run_read(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len,
      input logic [2:0] size, input logic [1:0] burst, input logic [7:0] pat);
    int cyc, issued, consumed, k;
    n_beats = 0; n_re = 0; max_out = 0; first_rv = -1; first_re = -1; last_cyc = -1;
    issued = 0; consumed = 0; k = 0;
    @(negedge clk_i);
    arid_i = id; araddr_i = addr; arlen_i = len; arsize_i = size; arburst_i = burst;
    arvalid_i = 1'b1;
    #1;
    while (!arready_o && k < 20) begin @(negedge clk_i); #1; k++; end
    @(negedge clk_i);
    arvalid_i = 1'b0;
    cyc = 1;
    while (n_beats < int'(len) + 1 && cyc < 80) begin
      rready_i = pat[cyc % 8];
      #1;
      if (mem_re_o) begin
        if (first_re < 0) first_re = cyc;
        if (n_re < 16) re_addr[n_re] = mem_raddr_o;
        n_re++; issued++;
      end
      if (rvalid_o) begin
        if (first_rv < 0) first_rv = cyc;
        if (rready_i) begin
          if (n_beats < 16) begin
            rd_data[n_beats] = rdata_o; rd_resp[n_beats] = rresp_o;
            rd_last[n_beats] = rlast_o; rd_id[n_beats] = rid_o;
          end
          n_beats++; consumed++; last_cyc = cyc;
        end
      end
      if (issued - consumed > max_out) max_out = issued - consumed;
      @(negedge clk_i);
      cyc++;
    end
    rready_i = 1'b0;
    n_checks++;
    if (n_beats != int'(len) + 1) begin
      n_fails++;
      $display("FAIL read_done: got %0d beats, required %0d", n_beats, int'(len) + 1);
    end
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0;
    repeat (3) @(negedge clk_i);
    #1;
    n_checks++;
    if ({awready_o, arready_o, wready_o, bvalid_o, rvalid_o, mem_we_o, mem_re_o} !== 7'b0) begin
      n_fails++;
      $display("FAIL reset_outputs: got %b, required 0000000",
               {awready_o, arready_o, wready_o, bvalid_o, rvalid_o, mem_we_o, mem_re_o});
    end
    @(negedge clk_i);
    rst_n_i = 1'b1;
    #1;
    n_checks++;
    if (awready_o !== 1'b0) begin n_fails++; $display("FAIL reset_release_awready: got %b, required 0", awready_o); end
    @(negedge clk_i);
    #1;
    n_checks++;
    if ({awready_o, arready_o} !== 2'b11) begin
      n_fails++; $display("FAIL reset_ready_rise: got %b, required 11", {awready_o, arready_o});
    end
  endtask

  task automatic test_incr_write();
    logic [9:0] exp_wa [4];
    exp_wa = '{10'd4, 10'd5, 10'd6, 10'd7};
    run_write(4'h5, 16'h0010, 8'd3, 3'd2, 2'b01, 32'd1, 4'hF, 3);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({we_log[i], wa_log[i], be_log[i], wd_log[i]} !== {1'b1, exp_wa[i], 4'hF, 32'(i + 1)}) begin
        n_fails++;
        $display("FAIL incr_write_beat%0d: got we=%b addr=%0d be=%h data=%0d, required we=1 addr=%0d be=f data=%0d",
                 i, we_log[i], wa_log[i], be_log[i], wd_log[i], exp_wa[i], i + 1);
      end
    end
    n_checks++;
    if ({b_seen, b_id, b_resp} !== {1'b1, 4'h5, 2'b00}) begin
      n_fails++; $display("FAIL incr_write_b: got valid=%b id=%h resp=%b, required 1 5 00", b_seen, b_id, b_resp);
    end
    #1;
    n_checks++;
    if (awready_o !== 1'b1) begin n_fails++; $display("FAIL incr_write_awready: got %b, required 1", awready_o); end
  endtask

  task automatic test_incr_read();
    run_read(4'h9, 16'h0010, 8'd3, 3'd2, 2'b01, 8'hFF);
    n_checks++;
    if (first_re !== 1 || first_rv !== 2 || last_cyc !== 5) begin
      n_fails++; $display("FAIL incr_read_timing: got re=%0d rv=%0d last=%0d, required 1 2 5", first_re, first_rv, last_cyc);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({rd_data[i], rd_resp[i], rd_last[i], rd_id[i]} !== {32'(i + 1), 2'b00, (i == 3), 4'h9}) begin
        n_fails++;
        $display("FAIL incr_read_beat%0d: got data=%0d resp=%b last=%b id=%h, required %0d 00 %0d 9",
                 i, rd_data[i], rd_resp[i], rd_last[i], rd_id[i], i + 1, (i == 3));
      end
    end
    #1;
    n_checks++;
    if ({arready_o, rvalid_o} !== 2'b10) begin
      n_fails++; $display("FAIL incr_read_end: got arready,rvalid=%b, required 10", {arready_o, rvalid_o});
    end
  endtask

  task automatic test_backpressure();
    run_read(4'h3, 16'h0010, 8'd3, 3'd2, 2'b01, 8'b1010_1001);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({rd_data[i], rd_last[i]} !== {32'(i + 1), (i == 3)}) begin
        n_fails++;
        $display("FAIL bp_beat%0d: got data=%0d last=%b, required %0d %0d", i, rd_data[i], rd_last[i], i + 1, (i == 3));
      end
    end
    n_checks++;
    if (n_re !== 4 || max_out > 2) begin
      n_fails++; $display("FAIL bp_outstanding: got reads=%0d max=%0d, required 4 and <=2", n_re, max_out);
    end
  endtask

  task automatic test_wrap_read();
    logic [9:0]  exp_a [4];
    logic [31:0] exp_d [4];
    exp_a = '{10'd6, 10'd7, 10'd4, 10'd5};
    exp_d = '{32'd3, 32'd4, 32'd1, 32'd2};
    run_read(4'h1, 16'h0018, 8'd3, 3'd2, 2'b10, 8'hFF);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({re_addr[i], rd_data[i], rd_resp[i]} !== {exp_a[i], exp_d[i], 2'b00}) begin
        n_fails++;
        $display("FAIL wrap_beat%0d: got addr=%0d data=%0d resp=%b, required %0d %0d 00",
                 i, re_addr[i], rd_data[i], rd_resp[i], exp_a[i], exp_d[i]);
      end
    end
    run_read(4'h2, 16'h0018, 8'd2, 3'd2, 2'b10, 8'hFF);
    n_checks++;
    if (n_re !== 0) begin n_fails++; $display("FAIL wrap_bad_reads: got %0d mem reads, required 0", n_re); end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({rd_data[i], rd_resp[i], rd_last[i]} !== {32'd0, 2'b10, (i == 2)}) begin
        n_fails++;
        $display("FAIL wrap_bad_beat%0d: got data=%0d resp=%b last=%b, required 0 10 %0d",
                 i, rd_data[i], rd_resp[i], rd_last[i], (i == 2));
      end
    end
  endtask

  task automatic test_narrow_write();
    run_write(4'h7, 16'h0003, 8'd1, 3'd0, 2'b01, 32'hA0, 4'hF, 0);
    n_checks++;
    if ({we_log[0], wa_log[0], be_log[0]} !== {1'b1, 10'd0, 4'b1000}) begin
      n_fails++; $display("FAIL narrow_beat0: got we=%b addr=%0d be=%b, required 1 0 1000", we_log[0], wa_log[0], be_log[0]);
    end
    n_checks++;
    if ({we_log[1], wa_log[1], be_log[1]} !== {1'b1, 10'd1, 4'b0001}) begin
      n_fails++; $display("FAIL narrow_beat1: got we=%b addr=%0d be=%b, required 1 1 0001", we_log[1], wa_log[1], be_log[1]);
    end
    n_checks++;
    if ({b_seen, b_id, b_resp} !== {1'b1, 4'h7, 2'b10}) begin
      n_fails++; $display("FAIL narrow_b: got valid=%b id=%h resp=%b, required 1 7 10", b_seen, b_id, b_resp);
    end
  endtask

  task automatic test_decerr_and_reset();
    run_write(4'hC, 16'h1000, 8'd0, 3'd2, 2'b01, 32'h55, 4'hF, 0);
    n_checks++;
    if ({we_log[0], b_seen, b_resp} !== {1'b0, 1'b1, 2'b11}) begin
      n_fails++; $display("FAIL decerr_write: got we=%b valid=%b resp=%b, required 0 1 11", we_log[0], b_seen, b_resp);
    end
    @(negedge clk_i);
    araddr_i = 16'h0010; arlen_i = 8'd3; arsize_i = 3'd2; arburst_i = 2'b01; arid_i = 4'h4;
    arvalid_i = 1'b1; rready_i = 1'b0;
    @(negedge clk_i);
    arvalid_i = 1'b0;
    repeat (2) @(negedge clk_i);
    #1;
    n_checks++;
    if (rvalid_o !== 1'b1) begin n_fails++; $display("FAIL rst_mid_pending: got rvalid=%b, required 1", rvalid_o); end
    rst_n_i = 1'b0;
    #1;
    n_checks++;
    if ({rvalid_o, arready_o, mem_re_o} !== 3'b000) begin
      n_fails++; $display("FAIL rst_mid_assert: got rvalid,arready,re=%b, required 000", {rvalid_o, arready_o, mem_re_o});
    end
    @(negedge clk_i);
    rst_n_i = 1'b1;
    @(negedge clk_i);
    #1;
    n_checks++;
    if ({rvalid_o, arready_o} !== 2'b01) begin
      n_fails++; $display("FAIL rst_mid_release: got rvalid,arready=%b, required 01", {rvalid_o, arready_o});
    end
    run_read(4'h6, 16'h0010, 8'd0, 3'd2, 2'b01, 8'hFF);
    n_checks++;
    if ({rd_data[0], rd_resp[0], rd_last[0], rd_id[0]} !== {32'd1, 2'b00, 1'b1, 4'h6}) begin
      n_fails++;
      $display("FAIL single_beat_read: got data=%0d resp=%b last=%b id=%h, required 1 00 1 6",
               rd_data[0], rd_resp[0], rd_last[0], rd_id[0]);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = '0;
    mem_rdata_i = '0;
    awid_i = '0; awaddr_i = '0; awlen_i = '0; awsize_i = '0; awburst_i = '0; awvalid_i = 1'b0;
    wdata_i = '0; wstrb_i = '0; wlast_i = 1'b0; wvalid_i = 1'b0; bready_i = 1'b0;
    arid_i = '0; araddr_i = '0; arlen_i = '0; arsize_i = '0; arburst_i = '0; arvalid_i = 1'b0;
    rready_i = 1'b0;
    test_reset();
    test_incr_write();
    test_incr_read();
    test_backpressure();
    test_wrap_read();
    test_narrow_write();
    test_decerr_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
